rom_sequencer: RTL and testbench
================================

Name: rom_sequencer

Overview:
- Address generator and output latch between the debounced button path and a synchronous-read ROM (16x8 default).
- Steps through ROM on a debounced step button, or free-runs with a programmable hold time per word.
- Latches each fetched word onto the LED outputs.
- Replaces the bare address counter clocked by the button; the whole design runs on the system clock.

Parameters:
- AW, 4, ROM address width; sequence length 2^AW.
- DW, 8, ROM data width / LED width.
- READ_LAT, 1, ROM read latency in clk cycles (>=1).
- CW, 24, hold counter width.
- HOLD_CYCLES, 12000000, cycles each word is shown in run mode (1 s at 12 MHz); must be >=1 and <2^CW.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- step  in  1  debounced button level; asynchronous to nothing (already synchronous to clk).
- run  in  1  level; 1 = auto-advance mode.
- rom_addr  out  AW  ROM address, registered.
- rom_data  in  DW  ROM output; reflects rom_addr READ_LAT edges after rom_addr changes.
- leds  out  DW  latched word, registered.
- busy  out  1  high in FETCH and LOAD.
- wrap  out  1  one-cycle pulse when rom_addr advances from 2^AW-1 to 0.

Behaviour:
- Step edge detect: step_q registers step. Edge at clk edge N when step=1 and step_q=0 there. A held level gives exactly one edge.
- Reset (rst=1 at an edge): rom_addr=0, leds=0, wrap=0, step_q=0, hold counter=0, state=FETCH, busy=1. Auto-loads rom[0].
- States: IDLE, FETCH, LOAD, HOLD.
- FETCH:
  - Wait counter counts READ_LAT cycles; rom_addr stable.
  - Then go to LOAD.
  - Step edges ignored (not queued).
- LOAD (1 cycle):
  - leds <= rom_data.
  - Next state HOLD if run=1, else IDLE.
  - Hold counter cleared.
- IDLE:
  - leds held.
  - On step edge or run=1: advance, go to FETCH.
- HOLD:
  - Hold counter increments each cycle.
  - run=0: go to IDLE; leds retained, rom_addr unchanged.
  - Step edge: advance immediately, go to FETCH.
  - Counter == HOLD_CYCLES-1: advance, go to FETCH.
  - Simultaneous step edge and timeout: single advance (+1, not +2).
- Advance: rom_addr <= rom_addr+1 modulo 2^AW. wrap=1 for that cycle only when the old address was 2^AW-1.
- Latency (READ_LAT=1): step edge at edge N gives rom_addr new at N, FETCH exit at N+1, leds updated at N+2. In general, leds update at N+READ_LAT+1.
- After reset release: leds=rom[0] at the (READ_LAT+1)th edge.
- rst mid-FETCH or mid-HOLD: immediate return to reset state; any partial timing discarded.

Optional Feature:
ROMSEQ_ONESHOT_EN
- Defined: an auto-advance (timeout, or run=1 from IDLE) at address 2^AW-1 does not wrap. State goes to IDLE and stays there until run deasserts and reasserts. step edges still advance and wrap normally; wrap still pulses on those.
- Undefined: run mode wraps continuously.

Test Plan:
- Bench setup: ROM model with READ_LAT=1 holding AA,55,AA,55,11,22,44,88,99,CC,FF,08,04,02,01,00; HOLD_CYCLES=4.
- Reset: assert rst 3 cycles, release -> rom_addr=0, leds=00 then AA 2 edges after release, busy high for exactly those 2 cycles.
- Manual step: run=0; step high for 10 cycles, 3 times with gaps -> exactly 3 advances, leds AA->55->AA->55, each update 2 edges after step rise.
- Wrap: 16 step pulses from addr 0 -> final rom_addr=0, leds=AA, wrap pulses exactly once (1 cycle) on the 15->0 advance.
- Run mode: run=1 from IDLE at addr 4 -> leds 11,22,44,88 with each word stable for 4 cycles in HOLD. Drop run mid-HOLD -> leds frozen, no further advance.
- Simultaneous/ignored events:
  - Step edge on the same cycle as HOLD timeout -> rom_addr +1 only.
  - Step edge during FETCH -> ignored.
  - rst during HOLD -> rom_addr=0, leds=00.
- ROMSEQ_ONESHOT_EN defined: run=1 from addr 14 -> leds 01, 00, then stops at addr 15 with no wrap pulse. A step edge then wraps to 0 and wrap pulses.

Source files
------------

// File: rtl/rom_sequencer.sv
// rom_sequencer: address generator and LED output latch for a synchronous-read ROM.
// Steps through the ROM on debounced button edges, or free-runs with a
// programmable hold time per word. Everything runs on the system clock.
// Build option ROMSEQ_ONESHOT_EN: run mode stops at the last address instead of
// wrapping and waits for run to be released and re-asserted; step edges still wrap.
module rom_sequencer #(
    parameter int AW          = 4,
    parameter int DW          = 8,
    parameter int READ_LAT    = 1,
    parameter int CW          = 24,
    parameter int HOLD_CYCLES = 12000000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step,
    input  logic          run,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic [DW-1:0] leds,
    output logic          busy,
    output logic          wrap
);

    localparam int            WW        = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(READ_LAT - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [AW-1:0] ADDR_LAST = {AW{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        LOAD,
        HOLD
    } state_t;

    state_t        state;
    state_t        next_state;
    logic          step_q;
    logic          step_edge;
    logic          run_eff;
    logic          at_stop;
    logic          advance;
    logic          set_block;
    logic          blocked;
    logic [WW-1:0] wait_cnt;
    logic [CW-1:0] hold_cnt;

    // A rising step level counts once; run is masked while a one-shot stop is pending.
    assign step_edge = step & ~step_q;
    assign run_eff   = run & ~blocked;
    assign busy      = (state == FETCH) || (state == LOAD);

`ifdef ROMSEQ_ONESHOT_EN
    assign at_stop = (rom_addr == ADDR_LAST);
`else
    assign at_stop = 1'b0;
`endif

    // State register; reset lands in FETCH so rom[0] is loaded automatically.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and advance request; a step edge and a timeout in the
    // same cycle produce one advance because both share the single advance flag.
    always_comb begin
        next_state = state;
        advance    = 1'b0;
        set_block  = 1'b0;
        case (state)
            FETCH: begin
                if (wait_cnt == WAIT_LAST) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                next_state = run_eff ? HOLD : IDLE;
            end
            IDLE: begin
                if (step_edge) begin
                    advance    = 1'b1;
                    next_state = FETCH;
                end else if (run_eff) begin
                    if (at_stop) begin
                        set_block = 1'b1;
                    end else begin
                        advance    = 1'b1;
                        next_state = FETCH;
                    end
                end
            end
            HOLD: begin
                if (step_edge) begin
                    advance    = 1'b1;
                    next_state = FETCH;
                end else if (!run_eff) begin
                    next_state = IDLE;
                end else if (hold_cnt == HOLD_LAST) begin
                    if (at_stop) begin
                        set_block  = 1'b1;
                        next_state = IDLE;
                    end else begin
                        advance    = 1'b1;
                        next_state = FETCH;
                    end
                end
            end
            default: begin
                next_state = FETCH;
            end
        endcase
    end

    // Datapath: address counter, LED latch, wait/hold counters and edge history.
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr <= '0;
            leds     <= '0;
            wrap     <= 1'b0;
            step_q   <= 1'b0;
            wait_cnt <= '0;
            hold_cnt <= '0;
            blocked  <= 1'b0;
        end else begin
            step_q <= step;
            wrap   <= advance && (rom_addr == ADDR_LAST);
            if (advance) begin
                rom_addr <= rom_addr + 1'b1;
            end
            if (state == LOAD) begin
                leds <= rom_data;
            end
            if ((state == FETCH) && (next_state == FETCH)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (state == LOAD) begin
                hold_cnt <= '0;
            end else if (state == HOLD) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
            if (!run) begin
                blocked <= 1'b0;
            end else if (set_block) begin
                blocked <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rom_sequencer.sv
// tb_rom_sequencer: scoreboard bench for rom_sequencer with a 16x8 ROM model,
// READ_LAT=1 and HOLD_CYCLES=4. Each expected LED update (value, address and
// edge number) is queued when stimulus is driven and popped when leds changes.
module tb_rom_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       step;
    logic       run;
    logic [3:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] leds;
    logic       busy;
    logic       wrap;

    typedef struct {
        logic [7:0] leds;
        logic [3:0] addr;
        int         cyc;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] rom_mem[16];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fails = 0;
    int         wrap_count = 0;
    int         wrap_cyc = 0;
    int         wrap_base;
    int         exp_wrap_cyc = 0;
    int         base;
    logic       mon_en = 1'b0;
    logic [7:0] prev_leds = 8'h00;
    logic [7:0] model_leds = 8'h00;
    logic [3:0] model_addr = 4'h0;

    rom_sequencer #(
        .AW(4),
        .DW(8),
        .READ_LAT(1),
        .CW(8),
        .HOLD_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .step(step),
        .run(run),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .leds(leds),
        .busy(busy),
        .wrap(wrap)
    );

    // System clock.
    always #5 clk = ~clk;

    // Edge counter, read on the falling edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read ROM with one cycle of latency.
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: observed %0h, expected %0h (edge %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic pushExp(input logic [7:0] l, input logic [3:0] a, input int c);
        exp_t e;
        e.leds = l;
        e.addr = a;
        e.cyc  = c;
        sb_q.push_back(e);
        model_leds = l;
        model_addr = a;
    endtask

    // One falling edge: observe outputs and retire scoreboard entries on LED changes.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (mon_en) begin
            if (wrap === 1'b1) begin
                wrap_count++;
                wrap_cyc = cyc;
            end
            if (leds !== prev_leds) begin
                if (sb_q.size() == 0) begin
                    checkOutput("spuriousLeds", 32'(leds), 32'(prev_leds));
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("ledsValue", 32'(leds), 32'(e.leds));
                    checkOutput("ledsAddr", 32'(rom_addr), 32'(e.addr));
                    checkOutput("ledsEdge", 32'(cyc), 32'(e.cyc));
                end
                prev_leds = leds;
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic rn, input int n);
        repeat (n) begin
            tick();
            rst  = r;
            step = s;
            run  = rn;
        end
    endtask

    // Button press in manual mode: the update lands two edges after the rising edge.
    task automatic pressStep(input int hold_n, input int gap_n);
        logic [3:0] next_addr;
        next_addr = model_addr + 4'd1;
        applyStimulus(1'b0, 1'b1, 1'b0, 1);
        if (model_addr == 4'hF) exp_wrap_cyc = cyc + 1;
        pushExp(rom_mem[next_addr], next_addr, cyc + 3);
        applyStimulus(1'b0, 1'b1, 1'b0, 1);
        checkOutput("stepBusy", 32'(busy), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, hold_n - 2);
        applyStimulus(1'b0, 1'b0, 1'b0, gap_n);
    endtask

    task automatic doReset(input int n);
        applyStimulus(1'b1, 1'b0, 1'b0, 1);
        if (model_leds != 8'h00) pushExp(8'h00, 4'h0, cyc + 1);
        model_addr = 4'h0;
        applyStimulus(1'b1, 1'b0, 1'b0, n - 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        pushExp(rom_mem[0], 4'h0, cyc + 2);
        applyStimulus(1'b0, 1'b0, 1'b0, 4);
    endtask

    // Main stimulus sequence.
    initial begin
        rom_mem = '{8'hAA, 8'h55, 8'hAA, 8'h55, 8'h11, 8'h22, 8'h44, 8'h88,
                    8'h99, 8'hCC, 8'hFF, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00};
        rst  = 1'b1;
        step = 1'b0;
        run  = 1'b0;

        // Reset held for three edges, then released.
        applyStimulus(1'b1, 1'b0, 1'b0, 2);
        checkOutput("rstAddr", 32'(rom_addr), 32'd0);
        checkOutput("rstLeds", 32'(leds), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd1);
        checkOutput("rstWrap", 32'(wrap), 32'd0);
        prev_leds = 8'h00;
        mon_en    = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        pushExp(rom_mem[0], 4'h0, cyc + 2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        checkOutput("relBusy1", 32'(busy), 32'd1);
        checkOutput("relLeds1", 32'(leds), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        checkOutput("relBusy2", 32'(busy), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 2);

        // Manual stepping with long held presses.
        for (int i = 0; i < 3; i++) pressStep(10, 5);
        checkOutput("manualAddr", 32'(rom_addr), 32'd3);
        checkOutput("manualBusy", 32'(busy), 32'd0);

        // Full lap of 16 presses from address 0.
        doReset(2);
        wrap_base = wrap_count;
        for (int i = 0; i < 16; i++) pressStep(2, 2);
        checkOutput("wrapCount", 32'(wrap_count - wrap_base), 32'd1);
        checkOutput("wrapEdge", 32'(wrap_cyc), 32'(exp_wrap_cyc));
        checkOutput("wrapAddr", 32'(rom_addr), 32'd0);
        checkOutput("wrapLeds", 32'(leds), 32'hAA);

        // Run mode from address 3, then drop run in the middle of HOLD.
        for (int i = 0; i < 3; i++) pressStep(2, 3);
        applyStimulus(1'b0, 1'b0, 1'b1, 1);
        base = cyc;
        for (int k = 0; k < 4; k++) pushExp(rom_mem[4 + k], 4'(4 + k), base + 3 + 6 * k);
        applyStimulus(1'b0, 1'b0, 1'b1, 21);
        applyStimulus(1'b0, 1'b0, 1'b0, 12);
        checkOutput("runStopAddr", 32'(rom_addr), 32'd7);
        checkOutput("runStopLeds", 32'(leds), 32'h88);
        checkOutput("runStopBusy", 32'(busy), 32'd0);

        // Step coinciding with a timeout, then a step edge inside FETCH.
        applyStimulus(1'b0, 1'b0, 1'b1, 1);
        base = cyc;
        for (int k = 0; k < 4; k++) pushExp(rom_mem[8 + k], 4'(8 + k), base + 3 + 6 * k);
        applyStimulus(1'b0, 1'b0, 1'b1, 5);
        applyStimulus(1'b0, 1'b1, 1'b1, 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 6);
        applyStimulus(1'b0, 1'b1, 1'b1, 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 8);
        applyStimulus(1'b0, 1'b0, 1'b0, 8);
        checkOutput("simulAddr", 32'(rom_addr), 32'd11);

        // Reset while holding a word in run mode.
        applyStimulus(1'b0, 1'b0, 1'b1, 1);
        pushExp(rom_mem[12], 4'd12, cyc + 3);
        applyStimulus(1'b0, 1'b0, 1'b1, 3);
        doReset(2);
        checkOutput("holdRstAddr", 32'(rom_addr), 32'd0);
        checkOutput("holdRstLeds", 32'(leds), 32'hAA);

        // Run from address 13 through the end of the ROM.
        for (int i = 0; i < 13; i++) pressStep(2, 2);
        wrap_base = wrap_count;
        applyStimulus(1'b0, 1'b0, 1'b1, 1);
        base = cyc;
        pushExp(rom_mem[14], 4'd14, base + 3);
        pushExp(rom_mem[15], 4'd15, base + 9);
`ifdef ROMSEQ_ONESHOT_EN
        applyStimulus(1'b0, 1'b0, 1'b1, 25);
        checkOutput("oneshotAddr", 32'(rom_addr), 32'd15);
        checkOutput("oneshotBusy", 32'(busy), 32'd0);
        checkOutput("oneshotNoWrap", 32'(wrap_count - wrap_base), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 2);
        pressStep(2, 3);
        checkOutput("oneshotStepWrap", 32'(wrap_count - wrap_base), 32'd1);
        checkOutput("oneshotWrapEdge", 32'(wrap_cyc), 32'(exp_wrap_cyc));
        checkOutput("oneshotStepAddr", 32'(rom_addr), 32'd0);
`else
        pushExp(rom_mem[0], 4'd0, base + 15);
        applyStimulus(1'b0, 1'b0, 1'b1, 15);
        applyStimulus(1'b0, 1'b0, 1'b0, 6);
        checkOutput("runWrapCount", 32'(wrap_count - wrap_base), 32'd1);
        checkOutput("runWrapEdge", 32'(wrap_cyc), 32'(base + 13));
        checkOutput("runWrapAddr", 32'(rom_addr), 32'd0);
`endif

        applyStimulus(1'b0, 1'b0, 1'b0, 4);
        checkOutput("sbDrain", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
